// File: rtl/or_result_deserializer_pkg.sv
// Shared types and helpers for the OR-result deserializer.
package or_deser_pkg;

  typedef enum logic [0:0] {COLLECT, HOLD} or_deser_state_t;

  function automatic int len_w(int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/or_result_deserializer_if.sv
// Upstream bit-pair stream and downstream word stream of the deserializer.
interface or_result_deserializer_if #(parameter int WIDTH = 8);
  import or_deser_pkg::*;

  logic                     up_valid;
  logic                     up_ready;
  logic                     up_a;
  logic                     up_b;
  logic                     up_last;
  logic                     down_valid;
  logic                     down_ready;
  logic [WIDTH-1:0]         down_data;
  logic [len_w(WIDTH)-1:0]  down_len;

  modport master (
    output up_valid, up_a, up_b, up_last, down_ready,
    input  up_ready, down_valid, down_data, down_len
  );

  modport slave (
    input  up_valid, up_a, up_b, up_last, down_ready,
    output up_ready, down_valid, down_data, down_len
  );

endinterface

// File: rtl/or_result_deserializer_or_gate.sv
// Two-input OR built from a 2:1 multiplexer: a selects constant 1, else b.
module or_gate_using_mux (
  input  logic a_i,
  input  logic b_i,
  output logic o_o
);

  assign o_o = a_i ? 1'b1 : b_i;

endmodule

// File: rtl/or_result_deserializer.sv
// Packs mux-OR result bits LSB-first into WIDTH-bit words with a length field.
module or_result_deserializer
  import or_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  or_result_deserializer_if.slave bus
);

  localparam int LEN_W = len_w(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  or_deser_state_t   state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d, acc_upd;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [LEN_W-1:0]  out_len_q, out_len_d, len_cur;
  logic              out_valid_q, out_valid_d;
  logic              up_ready;
  logic              res, beat, close, out_free, load_out;

  or_gate_using_mux u_or (
    .a_i (bus.up_a),
    .b_i (bus.up_b),
    .o_o (res)
  );

  assign beat     = bus.up_valid && (state_q == COLLECT);
  assign close    = beat && ((cnt_q == CNT_MAX) || bus.up_last);
  assign out_free = !out_valid_q || bus.down_ready;
  assign len_cur  = LEN_W'(cnt_q) + LEN_W'(1);
  // In HOLD the stored count is still the closing beat's index, so len_cur applies.
  assign load_out = (state_q == COLLECT) ? (close && out_free)
                                         : (out_valid_q && bus.down_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (close && !out_free) state_d = HOLD;
      HOLD:    if (out_valid_q && bus.down_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    up_ready = (state_q == COLLECT);
  end

  always_comb begin
    acc_upd        = acc_q;
    acc_upd[cnt_q] = res;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    out_data_d     = out_data_q;
    out_len_d      = out_len_q;
    out_valid_d    = out_valid_q;
    if (out_valid_q && bus.down_ready) out_valid_d = 1'b0;
    if (load_out) begin
      out_valid_d = 1'b1;
      out_data_d  = (state_q == HOLD) ? acc_q : acc_upd;
      out_len_d   = len_cur;
      acc_d       = '0;
      cnt_d       = '0;
    end else if (beat) begin
      acc_d = acc_upd;
      if (!close) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_len_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.up_ready   = up_ready;
  assign bus.down_valid = out_valid_q;
  assign bus.down_data  = out_data_q;
  assign bus.down_len   = out_len_q;

endmodule

// File: tb/tb_or_result_deserializer.sv
// Directed bench for or_result_deserializer at WIDTH = 4.
module tb_or_result_deserializer;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  or_result_deserializer_if #(.WIDTH(W)) bus ();

  or_result_deserializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic a, input logic b, input logic l);
    bus.up_valid = v;
    bus.up_a     = a;
    bus.up_b     = b;
    bus.up_last  = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [3:0] data, input logic [2:0] len);
    chk({tag, "_valid"}, 32'(bus.down_valid), 32'd1);
    chk({tag, "_data"},  32'(bus.down_data),  32'(data));
    chk({tag, "_len"},   32'(bus.down_len),   32'(len));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.down_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // 1: reset with random upstream activity
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    chk("rst_valid", 32'(bus.down_valid), 32'd0);
    chk("rst_data",  32'(bus.down_data),  32'd0);
    chk("rst_len",   32'(bus.down_len),   32'd0);
    chk("rst_ready", 32'(bus.up_ready),   32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_valid", 32'(bus.down_valid), 32'd0);

    // 2: full word
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();
    chk("full_early_valid", 32'(bus.down_valid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk_word("full", 4'b0110, 3'd4);
    tick();
    chk("full_one_cycle", 32'(bus.down_valid), 32'd0);

    // 3: early last; last without valid is ignored
    drive(1'b0, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1); tick();
    chk_word("early", 4'b0010, 3'd2);
    drive(1'b1, 1'b1, 1'b0, 1'b1); tick();
    chk_word("fresh", 4'b0001, 3'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("fresh_drained", 32'(bus.down_valid), 32'd0);

    // 4: backpressure
    bus.down_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
    end
    chk("bp_ready_before", 32'(bus.up_ready), 32'd1);
    chk_word("bp_first", 4'b1111, 3'd4);
    drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_ready_drop", 32'(bus.up_ready), 32'd0);
    tick(); tick();
    chk_word("bp_stable", 4'b1111, 3'd4);
    chk("bp_ready_held", 32'(bus.up_ready), 32'd0);
    bus.down_ready = 1'b1;
    tick();
    chk_word("bp_second", 4'b1111, 3'd4);
    chk("bp_ready_back", 32'(bus.up_ready), 32'd1);
    tick();
    chk("bp_drained", 32'(bus.down_valid), 32'd0);

    // 5: asynchronous reset mid-word
    drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.down_valid), 32'd0);
    chk("mid_rst_data",  32'(bus.down_data),  32'd0);
    chk("mid_rst_len",   32'(bus.down_len),   32'd0);
    #1 rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("mid_rst_no_early", 32'(bus.down_valid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk_word("mid_rst_word", 4'b0001, 3'd4);
    tick();

    // 6: new word completes in the cycle the previous one drains
    bus.down_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
    end
    chk_word("sim_prev", 4'b1111, 3'd4);
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("sim_ready_pre", 32'(bus.up_ready), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    bus.down_ready = 1'b1;
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sim_ready_post", 32'(bus.up_ready), 32'd1);
    chk_word("sim_new", 4'b1010, 3'd4);
    tick();
    chk("sim_drained", 32'(bus.down_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
